// File: rtl/mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM-stage access unit and the WB-stage load path:
//   - access-size codes carried on ex_size
//   - FSM state encoding for the sub-word read-modify-write sequence
//   - lane_extract: right-justify the addressed byte/halfword of a word
//   - lane_merge  : replace the addressed byte/halfword lane(s) of a word
// Byte lanes are little-endian: byte n occupies bits [8n+7:8n].
// ----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // RMW_RD names the read/capture transition out of IDLE; the register
    // goes straight from IDLE to RMW_WR, so RMW_RD is never held.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_e;

    // Selected lane moved to bit 0, upper bits zero. Words pass unchanged.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  byte_off,
        input logic [1:0]  size
    );
        logic [31:0] shifted;
        case (size)
            SIZE_BYTE: begin
                shifted = word >> {byte_off, 3'b000};
                return {24'b0, shifted[7:0]};
            end
            SIZE_HALF: begin
                shifted = word >> {byte_off[1], 4'b0000};
                return {16'b0, shifted[15:0]};
            end
            default: return word;
        endcase
    endfunction

    // old_word with the addressed lane(s) replaced by the low byte/halfword
    // of new_data. A word size replaces everything.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_data,
        input logic [1:0]  byte_off,
        input logic [1:0]  size
    );
        logic [31:0] mask;
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: begin
                mask  = 32'h0000_00FF << {byte_off, 3'b000};
                lanes = {4{new_data[7:0]}};
            end
            SIZE_HALF: begin
                mask  = 32'h0000_FFFF << {byte_off[1], 4'b0000};
                lanes = {2{new_data[15:0]}};
            end
            default: begin
                mask  = '1;
                lanes = new_data;
            end
        endcase
        return (old_word & ~mask) | (lanes & mask);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// DataMemory bus between the MEM-stage initiator and the word-wide memory.
//   MemRead, MemWrite : access strobes (never both high)
//   address           : word-aligned byte address
//   write_data        : store data
//   read_data         : combinational read data, valid while MemRead is high
// Modports: master (access unit), slave (DataMemory).
// ----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output MemRead,
        output MemWrite,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load formatter: selects the addressed byte/halfword lane of
// a memory word and sign- or zero-extends it to 32 bits.
//   word_i     : raw memory word
//   byte_off_i : byte address bits [1:0]
//   size_i     : access size code
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : register-file value
// ----------------------------------------------------------------------------
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);
    logic [31:0] raw;

    assign raw = lane_extract(word_i, byte_off_i, size_i);

    // NOTE: data_o is assigned on every path (default arm included); a path
    // that left it untouched would infer a latch.
    always_comb begin
        case (size_i)
            SIZE_BYTE: data_o = {{24{raw[7]  & ~unsigned_i}}, raw[7:0]};
            SIZE_HALF: data_o = {{16{raw[15] & ~unsigned_i}}, raw[15:0]};
            default:   data_o = raw;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage initiator for a word-only DataMemory. Loads of any size complete
// in one cycle (extracted and extended into wb_data); word stores write in
// one cycle; byte/halfword stores read the word, stall once, then write the
// merged word. Misaligned, illegal-size or read+write requests raise a
// one-cycle access_err and never strobe memory.
//   clk, reset        : clock, synchronous active-high reset
//   ex_*              : EX/MEM request (held stable while stall is high)
//   mem_bus           : DataMemory bus (master side)
//   stall             : high in the cycle that launches a read-modify-write
//   access_err        : registered error pulse
//   wb_*              : registered MEM/WB results
// ----------------------------------------------------------------------------
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // byte lanes assume exactly 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_rd,

    mem_access_unit_if.master mem_bus,

    output logic              stall,
    output logic              access_err,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);
    state_e            state_q;
    logic [DATA_W-1:0] merge_q;
    logic              access_err_q;
    logic              wb_valid_q;
    logic              wb_reg_write_q;
    logic [4:0]        wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;

    logic              misaligned;
    logic              req_err;
    logic              sub_word;
    logic              launch;
    logic              launch_err;
    logic              launch_load;
    logic              launch_store;
    logic              launch_rmw;
    logic              launch_word_store;
    logic              in_rmw_wr;
    logic [DATA_W-1:0] load_data;

    // ---------------- request decode ----------------
    always_comb begin
        case (ex_size)
            SIZE_HALF: misaligned = ex_addr[0];
            SIZE_WORD: misaligned = |ex_addr[1:0];
            default:   misaligned = 1'b0;
        endcase
    end

    assign req_err = (ex_mem_read | ex_mem_write) &
                     ((ex_size == SIZE_ILLEGAL) | (ex_mem_read & ex_mem_write) | misaligned);
    assign sub_word = (ex_size == SIZE_BYTE) | (ex_size == SIZE_HALF);

    // Every strobe qualifier includes ~reset so nothing reaches memory on a
    // reset edge, including the write half of an interrupted RMW.
    assign launch            = ~reset & ex_valid & (state_q == IDLE);
    assign launch_err        = launch & req_err;
    assign launch_load       = launch & ~req_err & ex_mem_read;
    assign launch_store      = launch & ~req_err & ex_mem_write;
    assign launch_rmw        = launch_store & sub_word;
    assign launch_word_store = launch_store & ~sub_word;
    assign in_rmw_wr         = ~reset & (state_q == RMW_WR);

    // ---------------- DataMemory bus ----------------
    assign mem_bus.MemRead    = launch_load | launch_rmw;
    assign mem_bus.MemWrite   = launch_word_store | in_rmw_wr;
    assign mem_bus.address    = reset ? '0 : {ex_addr[ADDR_W-1:2], 2'b00};
    assign mem_bus.write_data = in_rmw_wr         ? lane_merge(merge_q, ex_store_data, ex_addr[1:0], ex_size) :
                                launch_word_store ? ex_store_data : '0;

    assign stall = launch_rmw;

    load_extend u_load_extend (
        .word_i     (mem_bus.read_data),
        .byte_off_i (ex_addr[1:0]),
        .size_i     (ex_size),
        .unsigned_i (ex_unsigned),
        .data_o     (load_data)
    );

    // ---------------- FSM + MEM/WB registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: merge_q is a single data register, not a RAM array, so it
            // is cleared along with the control state at no real cost.
            state_q        <= IDLE;
            merge_q        <= '0;
            access_err_q   <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
        end else begin
            access_err_q <= launch_err;
            case (state_q)
                IDLE: begin
                    // The RMW launch cycle retires nothing; the store retires
                    // from RMW_WR.
                    wb_valid_q     <= ex_valid & ~launch_rmw;
                    wb_reg_write_q <= ex_valid & ~req_err & ~ex_mem_write & ex_reg_write;
                    wb_rd_q        <= ex_rd;
                    wb_data_q      <= launch_load ? load_data : ex_addr;
                    if (launch_rmw) begin
                        merge_q <= mem_bus.read_data;
                        state_q <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    state_q        <= IDLE;
                    wb_valid_q     <= 1'b1;
                    wb_reg_write_q <= 1'b0;
                    wb_rd_q        <= ex_rd;
                    wb_data_q      <= ex_addr;
                end
                default: begin
                    state_q        <= IDLE;
                    wb_valid_q     <= 1'b0;
                    wb_reg_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign access_err   = access_err_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Drives mem_access_unit against a word-wide DataMemory model and checks it
// against a byte-array reference memory that applies load/store rules
// directly (byte lists, arithmetic sign extension).
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic        regw;
        logic [4:0]  rdreg;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        access_err;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        preload_en;
    logic [7:0]  preload_idx;
    logic [31:0] preload_val;

    logic [31:0] dmem    [0:255];
    logic [7:0]  ref_mem [0:1023];

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .mem_bus       (bus.master),
        .stall         (stall),
        .access_err    (access_err),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data)
    );

    always #5 clk = ~clk;

    // DataMemory: combinational read, write on the rising edge.
    assign bus.read_data = dmem[bus.address[9:2]];
    always @(posedge clk) begin
        if (preload_en)
            dmem[preload_idx] <= preload_val;
        else if (bus.MemWrite)
            dmem[bus.address[9:2]] <= bus.write_data;
    end

    // ---------------- reference model ----------------
    function automatic int n_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'({a[9:2], 2'b00});
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input op_t op);
        int b, n;
        logic [31:0] v;
        b = int'(op.addr[9:0]);
        n = n_bytes(op.size);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[b+k]) << (8 * k));
        if (!op.uns && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input op_t op);
        int b, n;
        b = int'(op.addr[9:0]);
        n = n_bytes(op.size);
        for (int k = 0; k < n; k++) ref_mem[b+k] = op.data[8*k +: 8];
    endtask

    function automatic logic exp_err(input op_t op);
        if (!(op.rd || op.wr)) return 1'b0;
        if (op.rd && op.wr) return 1'b1;
        case (op.size)
            2'b11:   return 1'b1;
            2'b01:   return op.addr[0];
            2'b10:   return op.addr[1:0] != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] data, input logic regw,
                               input logic [4:0] rdreg);
        op_t op;
        op.rd = rd; op.wr = wr; op.size = size; op.uns = uns;
        op.addr = addr; op.data = data; op.regw = regw; op.rdreg = rdreg;
        return op;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        int  k;
        k = $urandom_range(0, 19);
        op.rd = 1'b0;
        op.wr = 1'b0;
        if (k < 8) op.rd = 1'b1;
        else if (k < 16) op.wr = 1'b1;
        else if (k >= 18) begin op.rd = 1'b1; op.wr = 1'b1; end
        op.size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        op.uns   = 1'($urandom_range(0, 1));
        op.addr  = $urandom;
        if ($urandom_range(0, 4) != 0) begin
            if (op.size == 2'b01) op.addr[0] = 1'b0;
            if (op.size == 2'b10) op.addr[1:0] = 2'b00;
        end
        op.data  = $urandom;
        op.regw  = 1'($urandom_range(0, 1));
        op.rdreg = 5'($urandom);
        return op;
    endfunction

    task automatic drive(input op_t op);
        ex_valid      = 1'b1;
        ex_mem_read   = op.rd;
        ex_mem_write  = op.wr;
        ex_size       = op.size;
        ex_unsigned   = op.uns;
        ex_addr       = op.addr;
        ex_store_data = op.data;
        ex_reg_write  = op.regw;
        ex_rd         = op.rdreg;
    endtask

    // One complete instruction followed by one idle (ex_valid=0) cycle.
    task automatic run_op(input op_t op, input string name);
        logic        err, rmw, e_rd, e_wr, e_regw;
        logic [31:0] e_load;
        err    = exp_err(op);
        rmw    = !err && op.wr && (op.size == 2'b00 || op.size == 2'b01);
        e_rd   = !err && (op.rd || rmw);
        e_wr   = !err && op.wr && op.size == 2'b10;
        e_regw = !err && !op.wr && op.regw;
        e_load = ref_load(op);

        @(negedge clk);
        drive(op);
        #1;
        checks++;
        if ({bus.MemRead, bus.MemWrite, stall} !== {e_rd, e_wr, rmw}) begin
            errors++;
            $display("FAIL %s strobes rd/wr/stall: got %b%b%b want %b%b%b", name,
                     bus.MemRead, bus.MemWrite, stall, e_rd, e_wr, rmw);
        end
        if (e_rd || e_wr) begin
            checks++;
            if (bus.address !== {op.addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL %s address: got %h want %h", name, bus.address, {op.addr[31:2], 2'b00});
            end
        end
        if (e_wr) begin
            checks++;
            if (bus.write_data !== op.data) begin
                errors++;
                $display("FAIL %s write_data: got %h want %h", name, bus.write_data, op.data);
            end
        end
        if (!err && op.wr) ref_store(op);

        if (rmw) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.MemRead, bus.MemWrite, stall} !== 3'b010) begin
                errors++;
                $display("FAIL %s rmw_wr strobes rd/wr/stall: got %b%b%b want 010", name,
                         bus.MemRead, bus.MemWrite, stall);
            end
            checks++;
            if (bus.write_data !== ref_word(op.addr) || bus.address !== {op.addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL %s rmw_wr data/addr: got %h@%h want %h@%h", name, bus.write_data,
                         bus.address, ref_word(op.addr), {op.addr[31:2], 2'b00});
            end
        end

        @(posedge clk);
        #1;
        checks++;
        if ({wb_valid, wb_reg_write, access_err, wb_rd} !== {1'b1, e_regw, err, op.rdreg}) begin
            errors++;
            $display("FAIL %s wb valid/regw/err/rd: got %b%b%b/%0d want %b%b%b/%0d", name,
                     wb_valid, wb_reg_write, access_err, wb_rd, 1'b1, e_regw, err, op.rdreg);
        end
        if (!err && !op.wr) begin
            checks++;
            if (wb_data !== (op.rd ? e_load : op.addr)) begin
                errors++;
                $display("FAIL %s wb_data: got %h want %h", name, wb_data, op.rd ? e_load : op.addr);
            end
        end

        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        checks++;
        if ({bus.MemRead, bus.MemWrite, stall} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle strobes: got %b%b%b want 000", name, bus.MemRead, bus.MemWrite, stall);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({wb_valid, access_err} !== 2'b00) begin
            errors++;
            $display("FAIL %s idle wb_valid/access_err: got %b%b want 00", name, wb_valid, access_err);
        end
        if (!err && op.wr) begin
            checks++;
            if (dmem[op.addr[9:2]] !== ref_word(op.addr)) begin
                errors++;
                $display("FAIL %s memory word: got %h want %h", name, dmem[op.addr[9:2]], ref_word(op.addr));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] w;
        reset      = 1'b1;
        drive(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0, 5'd0));
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            w           = $urandom;
            preload_en  = 1'b1;
            preload_idx = 8'(i);
            preload_val = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = w[8*k +: 8];
        end
        @(negedge clk);
        preload_en = 1'b0;
        #1;
        checks++;
        if ({bus.MemRead, bus.MemWrite, stall, bus.address, bus.write_data} !== 67'd0) begin
            errors++;
            $display("FAIL reset comb outputs: got rd=%b wr=%b stall=%b addr=%h wdata=%h want all 0",
                     bus.MemRead, bus.MemWrite, stall, bus.address, bus.write_data);
        end
        checks++;
        if ({wb_valid, wb_reg_write, access_err, wb_rd, wb_data} !== 40'd0) begin
            errors++;
            $display("FAIL reset wb regs: got v=%b rw=%b err=%b rd=%0d data=%h want all 0",
                     wb_valid, wb_reg_write, access_err, wb_rd, wb_data);
        end
        ex_valid = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_word_store_load();
        run_op(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5, 1'b0, 5'd0), "sw_0x10");
        run_op(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 5'd7), "lw_0x10");
        checks++;
        if (dmem[4] !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL sw_word_value: got %h want a5a5a5a5", dmem[4]);
        end
    endtask

    task automatic test_byte_rmw();
        run_op(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1234_5678, 1'b0, 5'd0), "sw_0x20");
        run_op(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0022, 32'h1111_11EF, 1'b0, 5'd0), "sb_0x22");
        checks++;
        if (dmem[8] !== 32'h12EF_5678) begin
            errors++;
            $display("FAIL sb_merged_value: got %h want 12ef5678", dmem[8]);
        end
    endtask

    task automatic test_subword_loads();
        run_op(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0, 1'b1, 5'd1), "lb_0x22");
        run_op(mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'h0, 1'b1, 5'd2), "lbu_0x22");
        run_op(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 1'b1, 5'd3), "lh_0x22");
        run_op(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 5'd4), "lh_neg");
    endtask

    task automatic test_misaligned();
        run_op(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0031, 32'h0, 1'b1, 5'd9), "lw_0x31");
        run_op(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_BEEF, 1'b0, 5'd0), "sh_0x13");
        run_op(mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 5'd9), "size_11");
        run_op(mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 1'b1, 5'd9), "rd_and_wr");
    endtask

    task automatic test_reset_mid_rmw();
        run_op(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 5'd0), "sw_0x40");
        @(negedge clk);
        drive(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0040, 32'h0000_BEEF, 1'b0, 5'd0));
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_rmw launch stall: got %b want 1", stall);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.MemRead, bus.MemWrite} !== 2'b00) begin
            errors++;
            $display("FAIL rst_rmw strobes under reset: got %b%b want 00", bus.MemRead, bus.MemWrite);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw wb_valid: got %b want 0", wb_valid);
        end
        @(negedge clk);
        reset    = 1'b0;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dmem[16] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rst_rmw memory word: got %h want cafef00d", dmem[16]);
        end
        run_op(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 5'd6), "lw_after_rst");
    endtask

    task automatic test_pass_through();
        run_op(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd5), "pass_through");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) run_op(rand_op(), "random");
    endtask

    initial begin
        preload_en  = 1'b0;
        preload_idx = '0;
        preload_val = '0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_subword_loads();
        test_misaligned();
        test_reset_mid_rmw();
        test_pass_through();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
